// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, updating on the falling clk edge; 1-edge latency, in_ready decoded from registered state only.
// Control bits are zeroed on bubbles and flush; optional saturating stall counter under `STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   main_data;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [DATA_W-1:0]   skid_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic                accept;
  logic                consume;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Squash wins over any beat offered on the same edge; payload left stale.
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (accept) begin
            state     <= TWO;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else if (consume) begin
            state     <= EMPTY;
            main_ctrl <= '0;
          end
        end
        TWO: begin
          if (consume) begin
            state     <= ONE;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
          end
        end
        default: begin
          state     <= EMPTY;
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Counts edges where a held beat is refused downstream; sticks at all-ones.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed stimulus with a scoreboard queue; a monitor pops and checks every beat the DUT hands downstream.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  logic              clk;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_ready;
  logic [CNT_W-1:0]  stall_cnt;

  int    n_cmp;
  int    n_bad;
  int    n_pop;
  beat_t sb[$];

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; the DUT samples them on the next falling edge.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    if (fl) sb.delete();
    else if (iv && in_ready) sb.push_back({d, c});
  endtask

  // Monitor: look just before the falling edge, where a consume actually happens.
  initial begin
    beat_t exp_b;
    forever begin
      @(posedge clk);
      #3;
      if (resetn) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got data 0x%0h with empty scoreboard", out_data);
          end else begin
            exp_b = sb.pop_front();
            n_pop++;
            check("out_data", out_data, exp_b.data);
            check("out_ctrl", {56'd0, out_ctrl}, {56'd0, exp_b.ctrl});
          end
        end else if (!out_valid) begin
          check("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
        end
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] exp_sat;
    n_cmp = 0; n_bad = 0; n_pop = 0;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;
`ifdef STALL_CNT_EN
    exp_sat = 4'hF;
`else
    exp_sat = 4'h0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    resetn = 1'b1;

    // Streaming 0x1..0x5 with out_ready held high
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'(i + 1), 8'hA5, 1'b1, 1'b0);
      check("stream_out_valid", {63'd0, out_valid}, (i > 0) ? 64'd1 : 64'd0);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("stream_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure into the skid entry
    step(1'b1, 64'h10, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 64'h11, 8'h3D, 1'b0, 1'b0);
    step(1'b1, 64'h12, 8'h3E, 1'b0, 1'b0);
    check("skid_in_ready", {63'd0, in_ready}, 64'd0);
    check("skid_hold_data", out_data, 64'h10);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("skid_hold_data2", out_data, 64'h10);
    check("skid_hold_ctrl", {56'd0, out_ctrl}, 64'h3C);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("skid_drained", {63'd0, out_valid}, 64'd0);

    // Bubble clearing after a single beat
    step(1'b1, 64'h20, 8'hFF, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("bubble_out_valid", {63'd0, out_valid}, 64'd0);
    check("bubble_out_ctrl", {56'd0, out_ctrl}, 64'd0);

    // Flush from TWO, then flush racing an accept in ONE
    step(1'b1, 64'h30, 8'h11, 1'b0, 1'b0);
    step(1'b1, 64'h31, 8'h12, 1'b0, 1'b0);
    step(1'b1, 64'h32, 8'h13, 1'b0, 1'b1);
    step(1'b1, 64'h34, 8'h14, 1'b0, 1'b0);
    check("flush_two_ready", {63'd0, in_ready}, 64'd1);
    step(1'b1, 64'h35, 8'h15, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    step(1'b1, 64'h36, 8'h16, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset while holding two entries
    step(1'b1, 64'h40, 8'h20, 1'b0, 1'b0);
    step(1'b1, 64'h41, 8'h21, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_full", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    sb.delete();
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_out_data", out_data, 64'd0);
    check("arst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Stall counter saturation (all-ones when enabled, constant zero otherwise)
    step(1'b1, 64'h50, 8'h55, 1'b0, 1'b0);
    repeat (21) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("stall_cnt_sat", {60'd0, stall_cnt}, {60'd0, exp_sat});
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("stall_cnt_hold", {60'd0, stall_cnt}, {60'd0, exp_sat});

    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("beats_seen", 64'(n_pop), 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
